fsmir_sched: RTL

- Schedules N byte-stream requesters onto one shared sequence checker.
- Checker interface: consumes one byte per clock on di; exposes state c and solved (c == 59). Any mismatching byte returns it to state 0. It has no reset and no stall input.
- fsmir_sched grants one requester at a time, round-robin, and flushes the checker to state 0 before each attempt. It streams the granted frame without gaps and reports pass/fail, requester id and length per attempt.

---
 rtl/fsmir_sched_pkg.sv | 17 +
 rtl/fsmir_rr_arb.sv | 38 +++
 rtl/fsmir_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fsmir_sched_pkg.sv
// fsmir_sched shared types and constants.
// Imported by the scheduler top and its arbiter.
package fsmir_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    STREAM,
    CHECK,
    RESULT
  } state_t;

  localparam logic [7:0] FLUSH_BYTE   = 8'h00;
  localparam logic [7:0] SOLVED_STATE = 8'd59;
  localparam int         LEN_W        = 7;

endpackage

// File: rtl/fsmir_rr_arb.sv
// Combinational round-robin picker.
// Chooses the first request at or after ptr, wrapping.
module fsmir_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] p,
    input int            k
  );
    int j;
    j = int'(p) + k;
    if (j >= N) j = j - N;
    return IW'(j);
  endfunction

  // scan from farthest to nearest so the nearest wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap(ptr, k)]) begin
        idx = wrap(ptr, k);
        any = 1'b1;
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/fsmir_sched.sv
// Round-robin scheduler of byte-stream requesters onto
// one shared sequence checker, with per-attempt results.
module fsmir_sched
  import fsmir_sched_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int LEN_MAX = 64,
  localparam int IW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         chk_di,
  input  logic [7:0]         chk_c,
  input  logic               chk_solved,
  output logic               res_valid,
  output logic [IW-1:0]      res_id,
  output logic               res_pass,
  output logic [LEN_W-1:0]   res_len,
  output logic               busy
);

  state_t state, state_d;

  logic [IW-1:0]    grant, grant_d;
  logic [N_REQ-1:0] gnt_oh, gnt_oh_d;
  logic [IW-1:0]    rr, rr_d;
  logic [LEN_W-1:0] cnt, cnt_d;
  logic [IW-1:0]    res_id_d;
  logic             res_pass_d;
  logic [LEN_W-1:0] res_len_d;
  logic             load_res;
  logic             pass_v;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  fsmir_rr_arb #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      gnt_oh   <= '0;
      rr       <= '0;
      cnt      <= '0;
      res_id   <= '0;
      res_pass <= 1'b0;
      res_len  <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      gnt_oh   <= gnt_oh_d;
      rr       <= rr_d;
      cnt      <= cnt_d;
      res_id   <= res_id_d;
      res_pass <= res_pass_d;
      res_len  <= res_len_d;
    end
  end

  always_comb begin
    state_d    = state;
    grant_d    = grant;
    gnt_oh_d   = gnt_oh;
    rr_d       = rr;
    cnt_d      = cnt;
    res_id_d   = res_id;
    res_pass_d = res_pass;
    res_len_d  = res_len;
    load_res   = 1'b0;
    pass_v     = 1'b0;
    req_ready  = '0;
    chk_di     = FLUSH_BYTE;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          grant_d  = arb_idx;
          gnt_oh_d = arb_gnt;
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        req_ready = gnt_oh;
        if (req_valid[grant]) begin
          chk_di = req_data[{grant, 3'b000} +: 8];
          cnt_d  = cnt + 1'b1;
          if (req_last[grant]) begin
            state_d = CHECK;
          end else if (cnt_d == LEN_W'(LEN_MAX)) begin
            load_res = 1'b1;
            state_d  = RESULT;
          end
        end else begin
          load_res = 1'b1;
          state_d  = RESULT;
        end
      end
      CHECK: begin
        // checker has one cycle of latency
        pass_v   = chk_solved;
        load_res = 1'b1;
        state_d  = RESULT;
      end
      RESULT: begin
        rr_d    = (grant == IW'(N_REQ - 1)) ? '0
                                            : grant + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load_res) begin
      res_id_d   = grant;
      res_pass_d = pass_v;
      res_len_d  = cnt_d;
    end
  end

  assign res_valid = (state == RESULT);
  assign busy      = (state != IDLE);

  chk_solved_at_state: assert property (
    @(posedge clk) disable iff (!rst_n)
    chk_solved |-> chk_c == SOLVED_STATE
  );

endmodule
